// File: rtl/dbp_bht_sched.sv
// dbp_bht_sched
//   Owns channel 2 of the branch history table. Each cycle it does exactly one
//   of: a clear-sweep write, a read grant, a queued update write, or nothing.
//   Resolved-branch updates from the DBP are buffered in a small FIFO. They are
//   written into the table whenever channel 2 is not needed for a read.
//
// Optional feature (macro DBP_BHT_SCHED_CLEAR_EN):
//   defined   - power-up clear sweep and a clr_req-triggered clear sweep
//   undefined - no sweep; clr_req is ignored; clr_busy_o is tied low
//
// Ports
//   clk_i, reset_i                  clock, async active-high reset
//   upd_valid_i/upd_ready_o         update handshake (upd_addr_i, upd_data_i)
//   rd_valid_i, rd_addr_i           channel-2 read request
//   rd_ready_o, rd_rvalid_o         read grant, table data valid one cycle later
//   clr_req_i, clr_busy_o           clear request pulse, sweep in progress
//   bht_add2_o/bht_wen2_o/bht_wdata2_o  table channel-2 controls
//   q_count_o                       number of queued updates
//
// state    | meaning
// ST_IDLE  | queue empty (or first cycle after a sweep); reads only
// ST_DRAIN | queue non-empty; head written on any cycle without a read
// ST_CLEAR | sweep writing zero to one index per cycle
module dbp_bht_sched #(
   parameter int AWIDTH = 10,
   parameter int DWIDTH = 32,
   parameter int QDEPTH = 4
) (
   input  logic                    clk_i,
   input  logic                    reset_i,
   input  logic                    upd_valid_i,
   output logic                    upd_ready_o,
   input  logic [AWIDTH-1:0]       upd_addr_i,
   input  logic [DWIDTH-1:0]       upd_data_i,
   input  logic                    rd_valid_i,
   input  logic [AWIDTH-1:0]       rd_addr_i,
   output logic                    rd_ready_o,
   output logic                    rd_rvalid_o,
   input  logic                    clr_req_i,
   output logic                    clr_busy_o,
   output logic [AWIDTH-1:0]       bht_add2_o,
   output logic                    bht_wen2_o,
   output logic [DWIDTH-1:0]       bht_wdata2_o,
   output logic [$clog2(QDEPTH):0] q_count_o
);
   localparam int            PW       = $clog2(QDEPTH);
   localparam logic [PW:0]   CNT_FULL = (PW+1)'(QDEPTH);
   localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
   localparam logic [PW-1:0] PTR_ONE  = PW'(1);
   localparam logic [1:0]    ST_IDLE  = 2'd0;
   localparam logic [1:0]    ST_DRAIN = 2'd1;
`ifdef DBP_BHT_SCHED_CLEAR_EN
   localparam logic [1:0]    ST_CLEAR = 2'd2;
   localparam logic [1:0]    ST_RESET = ST_CLEAR;
   localparam logic [AWIDTH-1:0] SWEEP_LAST = '1;
`else
   localparam logic [1:0]    ST_RESET = ST_IDLE;
`endif

   logic [1:0]        state_q, state_d;
   logic [PW:0]       count_q, count_d;
   logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
   logic [AWIDTH-1:0] add_q;
   logic              rvalid_q;
   logic [AWIDTH-1:0] qa_q [QDEPTH];
   logic [DWIDTH-1:0] qd_q [QDEPTH];
   logic              push, pop, rd_grant;
`ifdef DBP_BHT_SCHED_CLEAR_EN
   logic [AWIDTH-1:0] sweep_q, sweep_d;
`endif

   // Handshakes are gated by reset so nothing is offered or granted while the
   // controller is held in reset.
   assign upd_ready_o = ~reset_i & (count_q != CNT_FULL);
   assign push        = upd_valid_i & upd_ready_o;
   assign rd_ready_o  = rd_grant;
   assign rd_rvalid_o = rvalid_q;
   assign q_count_o   = count_q;
`ifdef DBP_BHT_SCHED_CLEAR_EN
   assign clr_busy_o  = (state_q == ST_CLEAR);
`else
   // Without the clear feature the request has no effect.
   assign clr_busy_o  = clr_req_i & 1'b0;
`endif

   // Channel-2 arbitration: sweep, then read, then queued write.
   always_comb begin
      rd_grant     = 1'b0;
      pop          = 1'b0;
      bht_add2_o   = add_q;
      bht_wen2_o   = 1'b0;
      bht_wdata2_o = '0;
      if (!reset_i) begin
`ifdef DBP_BHT_SCHED_CLEAR_EN
         if (state_q == ST_CLEAR) begin
            bht_add2_o = sweep_q;
            bht_wen2_o = 1'b1;
         end else
`endif
         if (rd_valid_i) begin
            rd_grant   = 1'b1;
            bht_add2_o = rd_addr_i;
         end else if (state_q == ST_DRAIN) begin
            pop          = 1'b1;
            bht_add2_o   = qa_q[rd_ptr_q];
            bht_wdata2_o = qd_q[rd_ptr_q];
            bht_wen2_o   = 1'b1;
         end
      end
   end

   always_comb begin
      count_d = count_q;
      if (push && !pop)      count_d = count_q + CNT_ONE;
      else if (pop && !push) count_d = count_q - CNT_ONE;
      state_d = (count_d != '0) ? ST_DRAIN : ST_IDLE;
`ifdef DBP_BHT_SCHED_CLEAR_EN
      sweep_d = sweep_q;
      if (state_q == ST_CLEAR) begin
         // Sweep exits through IDLE; draining resumes on the following cycle.
         state_d = (sweep_q == SWEEP_LAST) ? ST_IDLE : ST_CLEAR;
         sweep_d = sweep_q + AWIDTH'(1);
      end
      if (clr_req_i) begin
         state_d = ST_CLEAR;
         sweep_d = '0;
      end
`endif
   end

   always_ff @(posedge clk_i) begin
      if (push) begin
         qa_q[wr_ptr_q] <= upd_addr_i;
         qd_q[wr_ptr_q] <= upd_data_i;
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q  <= ST_RESET;
         count_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         add_q    <= '0;
         rvalid_q <= 1'b0;
`ifdef DBP_BHT_SCHED_CLEAR_EN
         sweep_q  <= '0;
`endif
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         add_q    <= bht_add2_o;
         rvalid_q <= rd_grant;
         if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
         if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
`ifdef DBP_BHT_SCHED_CLEAR_EN
         sweep_q  <= sweep_d;
`endif
      end
   end

endmodule

// File: tb/tb_dbp_bht_sched.sv
// Testbench for dbp_bht_sched (AWIDTH=4, DWIDTH=16, QDEPTH=4).
// Reference model: the update queue is a SystemVerilog queue, the table
// contents a plain array. Each cycle the expected channel-2 action follows
// the priority rules: sweep, then read, then the oldest queued update.
module tb_dbp_bht_sched;
   localparam int AW = 4;
   localparam int DW = 16;
   localparam int QD = 4;
   localparam int DEPTH = 16;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          upd_valid = 1'b0, rd_valid = 1'b0, clr_req = 1'b0;
   logic [AW-1:0] upd_addr = '0, rd_addr = '0;
   logic [DW-1:0] upd_data = '0;
   logic          upd_ready, rd_ready, rd_rvalid, clr_busy, bht_wen2;
   logic [AW-1:0] bht_add2;
   logic [DW-1:0] bht_wdata2;
   logic [2:0]    q_count;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   dbp_bht_sched #(.AWIDTH(AW), .DWIDTH(DW), .QDEPTH(QD)) dut (
      .clk_i(clk), .reset_i(reset),
      .upd_valid_i(upd_valid), .upd_ready_o(upd_ready),
      .upd_addr_i(upd_addr), .upd_data_i(upd_data),
      .rd_valid_i(rd_valid), .rd_addr_i(rd_addr),
      .rd_ready_o(rd_ready), .rd_rvalid_o(rd_rvalid),
      .clr_req_i(clr_req), .clr_busy_o(clr_busy),
      .bht_add2_o(bht_add2), .bht_wen2_o(bht_wen2), .bht_wdata2_o(bht_wdata2),
      .q_count_o(q_count)
   );

   function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
      return 16'hA000 | DW'(a);
   endfunction

   // Simple synchronous table attached to channel 2.
   logic [DW-1:0] bht_mem [DEPTH];
   bit            bht_seen [DEPTH];
   logic [DW-1:0] bht_rdata = '0;
   always @(posedge clk) begin
      if (bht_wen2) begin
         bht_mem[bht_add2]  <= bht_wdata2;
         bht_seen[bht_add2] <= 1'b1;
      end
      bht_rdata <= bht_seen[bht_add2] ? bht_mem[bht_add2] : init_val(bht_add2);
   end

   // ---------------- reference model ----------------
   typedef struct packed { logic [AW-1:0] a; logic [DW-1:0] d; } upd_t;
   upd_t          mq[$];
   logic [DW-1:0] ref_mem [DEPTH];
   int            sweep;
   bit            gap;
   logic          m_rvalid;
   logic [DW-1:0] m_rdata;
   logic [AW-1:0] m_last_add;

   logic          e_ready, e_rd_ready, e_wen, e_rvalid, e_busy;
   logic [AW-1:0] e_add;
   logic [DW-1:0] e_wdata, e_rdata;
   logic [2:0]    e_count;
   logic          o_ready, o_rd_ready, o_wen, o_rvalid, o_busy;
   logic [AW-1:0] o_add;
   logic [DW-1:0] o_wdata, o_rdata;
   logic [2:0]    o_count;

   task automatic model_reset();
      mq.delete();
      m_rvalid   = 1'b0;
      m_rdata    = '0;
      m_last_add = '0;
      gap        = 1'b0;
`ifdef DBP_BHT_SCHED_CLEAR_EN
      sweep = 0;
`else
      sweep = -1;
`endif
   endtask

   // One clock cycle: drive inputs, predict, sample at negedge, commit model.
   task automatic step(input logic uv, input logic [AW-1:0] ua, input logic [DW-1:0] ud,
                       input logic rv, input logic [AW-1:0] ra, input logic cr);
      bit   do_pop;
      upd_t e;
      upd_valid = uv; upd_addr = ua; upd_data = ud;
      rd_valid = rv; rd_addr = ra; clr_req = cr;
      e_count = 3'(mq.size()); e_ready = (mq.size() < QD);
      e_rvalid = m_rvalid; e_rdata = m_rdata; e_busy = (sweep >= 0);
      e_rd_ready = 1'b0; e_wen = 1'b0; e_add = m_last_add; e_wdata = '0; do_pop = 1'b0;
      if (sweep >= 0) begin
         e_wen = 1'b1; e_add = AW'(sweep);
      end else if (rv) begin
         e_rd_ready = 1'b1; e_add = ra;
      end else if (mq.size() > 0 && !gap) begin
         e_wen = 1'b1; e_add = mq[0].a; e_wdata = mq[0].d; do_pop = 1'b1;
      end
      @(negedge clk);
      o_ready = upd_ready; o_rd_ready = rd_ready; o_wen = bht_wen2; o_rvalid = rd_rvalid;
      o_busy = clr_busy; o_add = bht_add2; o_wdata = bht_wdata2; o_rdata = bht_rdata;
      o_count = q_count;
      @(posedge clk);
      if (e_rd_ready) m_rdata = ref_mem[ra];
      m_rvalid = e_rd_ready;
      if (e_wen) ref_mem[e_add] = e_wdata;
      if (do_pop) void'(mq.pop_front());
      if (uv && e_ready) begin
         e.a = ua; e.d = ud; mq.push_back(e);
      end
      m_last_add = e_add;
      gap = 1'b0;
`ifdef DBP_BHT_SCHED_CLEAR_EN
      if (cr) sweep = 0;
      else if (sweep == DEPTH-1) begin sweep = -1; gap = 1'b1; end
      else if (sweep >= 0) sweep++;
`endif
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, '0, 1'b0);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      logic exp_busy;
`ifdef DBP_BHT_SCHED_CLEAR_EN
      exp_busy = 1'b1;
`else
      exp_busy = 1'b0;
`endif
      upd_valid = 1'b1; rd_valid = 1'b1; rd_addr = 4'h5; clr_req = 1'b0;
      #3 reset = 1'b1;
      #1;
      n_checks++; if (upd_ready !== 1'b0) $display("FAIL reset_upd_ready: got %b want 0", upd_ready); else n_pass++;
      n_checks++; if (rd_ready !== 1'b0) $display("FAIL reset_rd_ready: got %b want 0", rd_ready); else n_pass++;
      n_checks++; if (rd_rvalid !== 1'b0) $display("FAIL reset_rvalid: got %b want 0", rd_rvalid); else n_pass++;
      n_checks++; if (bht_wen2 !== 1'b0) $display("FAIL reset_wen: got %b want 0", bht_wen2); else n_pass++;
      n_checks++; if (bht_add2 !== 4'h0) $display("FAIL reset_add: got %h want 0", bht_add2); else n_pass++;
      n_checks++; if (bht_wdata2 !== 16'h0) $display("FAIL reset_wdata: got %h want 0", bht_wdata2); else n_pass++;
      n_checks++; if (q_count !== 3'd0) $display("FAIL reset_count: got %0d want 0", q_count); else n_pass++;
      n_checks++; if (clr_busy !== exp_busy) $display("FAIL reset_busy: got %b want %b", clr_busy, exp_busy); else n_pass++;
      @(posedge clk); #1;
      upd_valid = 1'b0; rd_valid = 1'b0;
      model_reset();
      reset = 1'b0;
   endtask

   task automatic test_power_up_clear();
`ifdef DBP_BHT_SCHED_CLEAR_EN
      for (int i = 0; i < DEPTH; i++) begin
         step(1'b0, '0, '0, 1'b0, '0, 1'b0);
         n_checks++; if (o_wen !== 1'b1 || o_add !== AW'(i) || o_wdata !== 16'h0 || o_busy !== 1'b1)
            $display("FAIL pup_sweep idx %0d: got wen %b add %h wdata %h busy %b want 1 %h 0 1", i, o_wen, o_add, o_wdata, o_busy, AW'(i));
         else n_pass++;
      end
      step(1'b0, '0, '0, 1'b0, '0, 1'b0);
      n_checks++; if (o_busy !== 1'b0 || o_wen !== 1'b0) $display("FAIL pup_done: got busy %b wen %b want 0 0", o_busy, o_wen); else n_pass++;
`else
      step(1'b0, '0, '0, 1'b0, '0, 1'b1);
      n_checks++; if (o_busy !== 1'b0 || o_wen !== 1'b0) $display("FAIL noclr_req: got busy %b wen %b want 0 0", o_busy, o_wen); else n_pass++;
      step(1'b0, '0, '0, 1'b0, '0, 1'b0);
      n_checks++; if (o_busy !== 1'b0 || o_wen !== 1'b0) $display("FAIL noclr_after: got busy %b wen %b want 0 0", o_busy, o_wen); else n_pass++;
`endif
   endtask

   task automatic test_queue_full();
      logic [DW-1:0] got_d[$];
      logic [AW-1:0] got_a[$];
      for (int k = 0; k < 5; k++) begin
         step(1'b1, AW'(k+1), DW'(16'h100+k), 1'b1, '0, 1'b0);
         n_checks++; if (o_ready !== (k < 4)) $display("FAIL full_ready push %0d: got %b want %b", k, o_ready, (k < 4)); else n_pass++;
      end
      for (int j = 0; j < 8; j++) begin
         step(j < 2, 4'h5, 16'h104, 1'b0, '0, 1'b0);
         if (j == 0) begin
            n_checks++; if (o_ready !== 1'b0) $display("FAIL full_hold_on_pop: got %b want 0", o_ready); else n_pass++;
         end
         if (j == 1) begin
            n_checks++; if (o_ready !== 1'b1) $display("FAIL full_release: got %b want 1", o_ready); else n_pass++;
         end
         if (o_wen) begin got_d.push_back(o_wdata); got_a.push_back(o_add); end
      end
      n_checks++; if (got_d.size() != 5) $display("FAIL full_write_count: got %0d want 5", got_d.size()); else n_pass++;
      for (int i = 0; i < got_d.size() && i < 5; i++) begin
         n_checks++; if (got_d[i] !== DW'(16'h100+i) || got_a[i] !== AW'(i+1))
            $display("FAIL full_order %0d: got %h@%h want %h@%h", i, got_d[i], got_a[i], DW'(16'h100+i), AW'(i+1));
         else n_pass++;
      end
   endtask

   task automatic test_read_priority();
      step(1'b1, 4'h2, 16'h0055, 1'b1, '0, 1'b0);
      step(1'b1, 4'h3, 16'h0066, 1'b1, '0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         step(1'b0, '0, '0, 1'b1, 4'hA, 1'b0);
         n_checks++; if (o_rd_ready !== 1'b1 || o_add !== 4'hA || o_wen !== 1'b0 || o_count !== 3'd2)
            $display("FAIL prio_read %0d: got rdy %b add %h wen %b cnt %0d want 1 a 0 2", i, o_rd_ready, o_add, o_wen, o_count);
         else n_pass++;
         if (i > 0) begin
            n_checks++; if (o_rvalid !== 1'b1) $display("FAIL prio_rvalid %0d: got %b want 1", i, o_rvalid); else n_pass++;
         end
      end
      step(1'b0, '0, '0, 1'b0, '0, 1'b0);
      n_checks++; if (o_rvalid !== 1'b1 || o_rdata !== e_rdata) $display("FAIL prio_last_rvalid: got %b %h want 1 %h", o_rvalid, o_rdata, e_rdata); else n_pass++;
      n_checks++; if (o_wen !== 1'b1 || o_add !== 4'h2 || o_wdata !== 16'h0055) $display("FAIL prio_drain1: got %b %h %h want 1 2 0055", o_wen, o_add, o_wdata); else n_pass++;
      step(1'b0, '0, '0, 1'b0, '0, 1'b0);
      n_checks++; if (o_wen !== 1'b1 || o_add !== 4'h3 || o_wdata !== 16'h0066) $display("FAIL prio_drain2: got %b %h %h want 1 3 0066", o_wen, o_add, o_wdata); else n_pass++;
      step(1'b0, '0, '0, 1'b0, '0, 1'b0);
      n_checks++; if (o_wen !== 1'b0 || o_count !== 3'd0 || o_add !== 4'h3) $display("FAIL prio_empty: got wen %b cnt %0d add %h want 0 0 3", o_wen, o_count, o_add); else n_pass++;
   endtask

   task automatic test_no_forwarding();
      step(1'b1, 4'h7, 16'h1234, 1'b1, 4'h7, 1'b0);
      n_checks++; if (o_rd_ready !== 1'b1) $display("FAIL nofwd_grant: got %b want 1", o_rd_ready); else n_pass++;
      step(1'b0, '0, '0, 1'b0, '0, 1'b0);
      n_checks++; if (o_rvalid !== 1'b1 || o_rdata !== e_rdata || o_rdata === 16'h1234)
         $display("FAIL nofwd_old: got %b %h want 1 %h", o_rvalid, o_rdata, e_rdata);
      else n_pass++;
      n_checks++; if (o_wen !== 1'b1 || o_add !== 4'h7 || o_wdata !== 16'h1234) $display("FAIL nofwd_write: got %b %h %h want 1 7 1234", o_wen, o_add, o_wdata); else n_pass++;
      step(1'b0, '0, '0, 1'b1, 4'h7, 1'b0);
      step(1'b0, '0, '0, 1'b0, '0, 1'b0);
      n_checks++; if (o_rvalid !== 1'b1 || o_rdata !== 16'h1234) $display("FAIL nofwd_new: got %b %h want 1 1234", o_rvalid, o_rdata); else n_pass++;
   endtask

   task automatic test_clear_restart();
`ifdef DBP_BHT_SCHED_CLEAR_EN
      step(1'b0, '0, '0, 1'b0, '0, 1'b1);
      for (int i = 0; i < 10; i++) begin
         step(i == 3, 4'hC, 16'hBEEF, 1'b0, '0, i == 9);
         n_checks++; if (o_wen !== 1'b1 || o_add !== AW'(i) || o_busy !== 1'b1)
            $display("FAIL clr_first idx %0d: got wen %b add %h busy %b", i, o_wen, o_add, o_busy);
         else n_pass++;
      end
      for (int i = 0; i < DEPTH; i++) begin
         step(1'b0, '0, '0, 1'b1, 4'h1, 1'b0);
         n_checks++; if (o_wen !== 1'b1 || o_add !== AW'(i) || o_wdata !== 16'h0 || o_rd_ready !== 1'b0)
            $display("FAIL clr_restart idx %0d: got wen %b add %h wdata %h rdy %b", i, o_wen, o_add, o_wdata, o_rd_ready);
         else n_pass++;
      end
      step(1'b0, '0, '0, 1'b0, '0, 1'b0);
      n_checks++; if (o_busy !== 1'b0 || o_wen !== 1'b0 || o_count !== 3'd1) $display("FAIL clr_exit: got busy %b wen %b cnt %0d want 0 0 1", o_busy, o_wen, o_count); else n_pass++;
      step(1'b0, '0, '0, 1'b0, '0, 1'b0);
      n_checks++; if (o_wen !== 1'b1 || o_add !== 4'hC || o_wdata !== 16'hBEEF) $display("FAIL clr_queued: got %b %h %h want 1 c beef", o_wen, o_add, o_wdata); else n_pass++;
`endif
   endtask

   task automatic test_random_traffic();
      for (int c = 0; c < 400; c++) begin
         step(1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom), $urandom_range(0, 9) < 3,
              AW'($urandom), $urandom_range(0, 49) == 0);
         n_checks++; if (o_ready !== e_ready) $display("FAIL rnd_ready c%0d: got %b want %b", c, o_ready, e_ready); else n_pass++;
         n_checks++; if (o_rd_ready !== e_rd_ready) $display("FAIL rnd_rd_ready c%0d: got %b want %b", c, o_rd_ready, e_rd_ready); else n_pass++;
         n_checks++; if (o_wen !== e_wen) $display("FAIL rnd_wen c%0d: got %b want %b", c, o_wen, e_wen); else n_pass++;
         n_checks++; if (o_add !== e_add) $display("FAIL rnd_add c%0d: got %h want %h", c, o_add, e_add); else n_pass++;
         n_checks++; if (o_wdata !== e_wdata) $display("FAIL rnd_wdata c%0d: got %h want %h", c, o_wdata, e_wdata); else n_pass++;
         n_checks++; if (o_rvalid !== e_rvalid) $display("FAIL rnd_rvalid c%0d: got %b want %b", c, o_rvalid, e_rvalid); else n_pass++;
         n_checks++; if (o_count !== e_count) $display("FAIL rnd_count c%0d: got %0d want %0d", c, o_count, e_count); else n_pass++;
         n_checks++; if (o_busy !== e_busy) $display("FAIL rnd_busy c%0d: got %b want %b", c, o_busy, e_busy); else n_pass++;
         if (e_rvalid) begin
            n_checks++; if (o_rdata !== e_rdata) $display("FAIL rnd_rdata c%0d: got %h want %h", c, o_rdata, e_rdata); else n_pass++;
         end
      end
   endtask

   task automatic test_reset_mid_drain();
      logic exp_busy;
`ifdef DBP_BHT_SCHED_CLEAR_EN
      exp_busy = 1'b1;
`else
      exp_busy = 1'b0;
`endif
      for (int k = 0; k < 3; k++) step(1'b1, AW'(k+8), DW'(16'h300+k), 1'b1, 4'h1, 1'b0);
      upd_valid = 1'b0; rd_valid = 1'b0; clr_req = 1'b0;
      #1;
      n_checks++; if (q_count !== 3'd3 || bht_wen2 !== 1'b1) $display("FAIL mid_pre: got cnt %0d wen %b want 3 1", q_count, bht_wen2); else n_pass++;
      #1 reset = 1'b1;
      #1;
      n_checks++; if (bht_wen2 !== 1'b0 || bht_add2 !== 4'h0 || bht_wdata2 !== 16'h0)
         $display("FAIL mid_bht: got wen %b add %h wdata %h want 0 0 0", bht_wen2, bht_add2, bht_wdata2);
      else n_pass++;
      n_checks++; if (q_count !== 3'd0 || upd_ready !== 1'b0 || rd_ready !== 1'b0 || rd_rvalid !== 1'b0)
         $display("FAIL mid_ctl: got cnt %0d urdy %b rrdy %b rv %b want 0 0 0 0", q_count, upd_ready, rd_ready, rd_rvalid);
      else n_pass++;
      n_checks++; if (clr_busy !== exp_busy) $display("FAIL mid_busy: got %b want %b", clr_busy, exp_busy); else n_pass++;
      @(posedge clk); #1;
      model_reset();
      reset = 1'b0;
      step(1'b0, '0, '0, 1'b0, '0, 1'b0);
      n_checks++; if (o_count !== 3'd0 || o_wen !== exp_busy || o_add !== 4'h0)
         $display("FAIL mid_after: got cnt %0d wen %b add %h want 0 %b 0", o_count, o_wen, o_add, exp_busy);
      else n_pass++;
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_val(AW'(i));
      model_reset();
      test_reset();
      test_power_up_clear();
      test_queue_full();
      idle(3);
      test_read_priority();
      idle(2);
      test_no_forwarding();
      idle(3);
      test_clear_restart();
      idle(3);
      test_random_traffic();
      test_reset_mid_drain();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
